aurora_hls_rx_fifo: RTL and testbench

Receive-side buffer between the Aurora core RX AXI-Stream and the HLS consumer kernel.
The Aurora RX interface has no tready, so this block absorbs every beat, stores it, and presents it on a back-pressurable AXI-Stream master.
It generates the registered prog_full/prog_empty levels that drive the NFC XOFF/XON generator directly downstream of its flag outputs.
A beat that arrives while full is dropped and flagged.

---
 rtl/aurora_hls_pkg.sv | 22 ++
 rtl/aurora_hls_rx_fifo_ram.sv | 27 ++
 rtl/aurora_hls_rx_fifo.sv | 167 ++++++++++++++++
 tb/tb_aurora_hls_rx_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aurora_hls_pkg.sv
// Shared constants, helpers and beat layout for the Aurora HLS RX buffer.
package aurora_hls_pkg;

    localparam int AURORA_DATA_WIDTH        = 512;
    localparam int AURORA_DEPTH             = 512;
    localparam int AURORA_PROG_FULL_THRESH  = 384;
    localparam int AURORA_PROG_EMPTY_THRESH = 128;

    // A fill counter must be able to represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Beat layout at the default width; modules with other widths declare
    // the same field order locally so RAM packing stays consistent.
    typedef struct packed {
        logic [AURORA_DATA_WIDTH-1:0]   tdata;
        logic [AURORA_DATA_WIDTH/8-1:0] tkeep;
        logic                           tlast;
    } aurora_beat_t;

endpackage

// File: rtl/aurora_hls_rx_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module aurora_hls_rx_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port plus registered read; read-during-write returns old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/aurora_hls_rx_fifo.sv
// Aurora RX -> HLS FWFT buffer with registered prog_full/prog_empty flags.
// Optional macro AURORA_HLS_RX_FIFO_OVF_CNT_EN adds ovf_count and max_fill.
module aurora_hls_rx_fifo
    import aurora_hls_pkg::*;
#(
    parameter int DATA_WIDTH        = AURORA_DATA_WIDTH,
    parameter int DEPTH             = AURORA_DEPTH,
    parameter int PROG_FULL_THRESH  = AURORA_PROG_FULL_THRESH,
    parameter int PROG_EMPTY_THRESH = AURORA_PROG_EMPTY_THRESH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]         s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [count_width(DEPTH)-1:0]   fill_level,
    output logic                            prog_full,
    output logic                            prog_empty,
`ifdef AURORA_HLS_RX_FIFO_OVF_CNT_EN
    output logic [31:0]                     ovf_count,
    output logic [count_width(DEPTH)-1:0]   max_fill,
`endif
    output logic                            overflow
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int CW = count_width(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = DATA_WIDTH + KW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESH);

    if (!(PROG_EMPTY_THRESH < PROG_FULL_THRESH && PROG_FULL_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("aurora_hls_rx_fifo: need PROG_EMPTY_THRESH < PROG_FULL_THRESH <= DEPTH");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("aurora_hls_rx_fifo: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("aurora_hls_rx_fifo: DEPTH must be a power of two >= 4");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [KW-1:0]         tkeep;
        logic                  tlast;
    } beat_t;

    logic [CW-1:0] fill_q, fill_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          out_valid_q, out_valid_d;
    beat_t         out_beat_q, out_beat_d;
    logic          fwd_sel_q, fwd_sel_d;
    beat_t         fwd_beat_q;
    logic          prog_full_q, prog_empty_q, overflow_q;

    logic          push, pop, load_out, ram_rd, bypass, ram_we;
    logic [CW-1:0] ram_count;
    beat_t         in_beat, head_beat;
    logic [BW-1:0] ram_rdata;

    assign in_beat   = '{tdata: s_axis_tdata, tkeep: s_axis_tkeep, tlast: s_axis_tlast};
    // A word written into the RAM at the address being read in the same cycle
    // is not visible on the registered read port yet, so it is forwarded.
    assign head_beat = fwd_sel_q ? fwd_beat_q : beat_t'(ram_rdata);

    // Push/pop decisions and routing between bypass, RAM and output register.
    always_comb begin
        push      = s_axis_tvalid && (fill_q < DEPTH_C);
        pop       = out_valid_q && m_axis_tready;
        ram_count = fill_q - CW'(out_valid_q);
        load_out  = !out_valid_q || pop;
        ram_rd    = load_out && (ram_count != '0);
        bypass    = load_out && (ram_count == '0) && push;
        ram_we    = push && !bypass;
        fill_d    = fill_q + CW'(push) - CW'(pop);
        wr_ptr_d  = wr_ptr_q + AW'(ram_we);
        rd_ptr_d  = rd_ptr_q + AW'(ram_rd);
        fwd_sel_d = ram_we && (wr_ptr_q == rd_ptr_d);
        out_valid_d = (out_valid_q && !pop) || ram_rd || bypass;
        out_beat_d  = out_beat_q;
        if (ram_rd) begin
            out_beat_d = head_beat;
        end else if (bypass) begin
            out_beat_d = in_beat;
        end
    end

    // Control state, output register and registered level flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            fwd_sel_q    <= 1'b0;
            fwd_beat_q   <= '0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            fwd_sel_q    <= fwd_sel_d;
            fwd_beat_q   <= in_beat;
            prog_full_q  <= (fill_d >= PF_C);
            prog_empty_q <= (fill_d <= PE_C);
            overflow_q   <= overflow_q || (s_axis_tvalid && !push);
        end
    end

    aurora_hls_rx_fifo_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_beat),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

`ifdef AURORA_HLS_RX_FIFO_OVF_CNT_EN
    logic [31:0]   ovf_count_q;
    logic [CW-1:0] max_fill_q;

    // Saturating drop counter and fill high-water mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
            max_fill_q  <= '0;
        end else begin
            if (s_axis_tvalid && !push && ovf_count_q != 32'hFFFF_FFFF) begin
                ovf_count_q <= ovf_count_q + 32'd1;
            end
            if (fill_d > max_fill_q) begin
                max_fill_q <= fill_d;
            end
        end
    end

    assign ovf_count = ovf_count_q;
    assign max_fill  = max_fill_q;
`endif

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_beat_q.tdata;
    assign m_axis_tkeep  = out_beat_q.tkeep;
    assign m_axis_tlast  = out_beat_q.tlast;
    assign fill_level    = fill_q;
    assign prog_full     = prog_full_q;
    assign prog_empty    = prog_empty_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_aurora_hls_rx_fifo.sv
// Directed self-checking bench for aurora_hls_rx_fifo (32-bit, depth 16).
module tb_aurora_hls_rx_fifo;

    localparam int DW = 32;
    localparam int DP = 16;
    localparam int PF = 12;
    localparam int PE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic [3:0]    s_axis_tkeep  = '0;
    logic          s_axis_tlast  = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic [4:0]    fill_level;
    logic          prog_full, prog_empty, overflow;
`ifdef AURORA_HLS_RX_FIFO_OVF_CNT_EN
    logic [31:0]   ovf_count;
    logic [4:0]    max_fill;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    aurora_hls_rx_fifo #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DP),
        .PROG_FULL_THRESH  (PF),
        .PROG_EMPTY_THRESH (PE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .fill_level    (fill_level),
        .prog_full     (prog_full),
        .prog_empty    (prog_empty),
`ifdef AURORA_HLS_RX_FIFO_OVF_CNT_EN
        .ovf_count     (ovf_count),
        .max_fill      (max_fill),
`endif
        .overflow      (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] d);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b0;
        step();
        s_axis_tvalid = 1'b0;
    endtask

    // Pop n words with tready=1, expecting start, start+1, ... in order.
    task automatic drain(input int n, input int start);
        m_axis_tready = 1'b1;
        for (int k = 0; k < n; k++) begin
            check("drain_valid", 32'(m_axis_tvalid), 32'd1);
            check("drain_data", m_axis_tdata, 32'(start + k));
            step();
        end
        m_axis_tready = 1'b0;
        check("drain_fill", 32'(fill_level), 32'd0);
        check("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        // 1. Reset and idle
        step(); step();
        rst = 1'b0;
        step();
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_pe", 32'(prog_empty), 32'd1);
        check("rst_pf", 32'(prog_full), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);

        // 2. Single beat, stalled, then popped
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEADBEEF;
        s_axis_tkeep  = 4'hF;
        s_axis_tlast  = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("single_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("single_tkeep", 32'(m_axis_tkeep), 32'hF);
        check("single_tlast", 32'(m_axis_tlast), 32'd1);
        check("single_fill", 32'(fill_level), 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_tdata", m_axis_tdata, 32'hDEADBEEF);
            check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
        end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("pop_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("pop_fill", 32'(fill_level), 32'd0);

        // 3. Threshold crossings while filling to 12
        for (int i = 0; i < 12; i++) begin
            push_beat(32'(i));
            check("fill_lvl", 32'(fill_level), 32'(i + 1));
            check("fill_pe", 32'(prog_empty), 32'((i + 1) <= PE));
            check("fill_pf", 32'(prog_full), 32'((i + 1) >= PF));
        end
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check("pop1_fill", 32'(fill_level), 32'd11);
        check("pop1_pf", 32'(prog_full), 32'd0);
        drain(11, 1);

        // 4. Overflow: 18 pushes into depth 16
        for (int i = 0; i < 18; i++) begin
            push_beat(32'(i));
        end
        check("ovf_fill", 32'(fill_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_pf", 32'(prog_full), 32'd1);
`ifdef AURORA_HLS_RX_FIFO_OVF_CNT_EN
        check("ovf_count", ovf_count, 32'd2);
        check("max_fill", 32'(max_fill), 32'd16);
`endif
        drain(16, 0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // 5. Streaming with tready held high
        m_axis_tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 32'(100 + i);
            step();
            check("stream_valid", 32'(m_axis_tvalid), 32'd1);
            check("stream_data", m_axis_tdata, 32'(100 + i));
            check("stream_fill", 32'(fill_level), 32'd1);
            check("stream_pe", 32'(prog_empty), 32'd1);
        end
        s_axis_tvalid = 1'b0;
        step();
        m_axis_tready = 1'b0;
        check("stream_end_fill", 32'(fill_level), 32'd0);
        check("stream_end_valid", 32'(m_axis_tvalid), 32'd0);

        // 6. Mid-stream reset
        for (int i = 0; i < 9; i++) begin
            push_beat(32'(50 + i));
        end
        check("pre_rst_fill", 32'(fill_level), 32'd9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_fill", 32'(fill_level), 32'd0);
        check("mrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mrst_pe", 32'(prog_empty), 32'd1);
        check("mrst_ovf", 32'(overflow), 32'd0);
        push_beat(32'h0000A5A5);
        check("post_rst_valid", 32'(m_axis_tvalid), 32'd1);
        check("post_rst_data", m_axis_tdata, 32'h0000A5A5);
        check("post_rst_fill", 32'(fill_level), 32'd1);

        // 7. Push while full with simultaneous pop: push dropped, fill - 1
        for (int i = 0; i < 15; i++) begin
            push_beat(32'(200 + i));
        end
        check("full_fill", 32'(fill_level), 32'd16);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'd999;
        m_axis_tready = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        check("fullpop_fill", 32'(fill_level), 32'd15);
        check("fullpop_ovf", 32'(overflow), 32'd1);
        drain(15, 200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
